// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package cpu_mem_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 12;
  localparam int unsigned DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_CPU = 1'b0;
  localparam owner_t OWNER_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for an arbitration cycle in IDLE.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise the CPU always wins.
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t last_owner,
  output owner_t winner
);

  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = OWNER_CPU;
    if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = ~last_owner;
`else
      winner = OWNER_CPU;
`endif
    end else if (req1) begin
      winner = OWNER_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between the CPU (requester 0) and a DMA engine (requester 1)
// with a burst limit. Build with ARB_ROUND_ROBIN_EN for round-robin tie-break in IDLE.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] BurstMax = 8'(MAX_BURST);

  arb_state_t state;
  logic [7:0] burst_cnt;
  owner_t     last_owner;
  logic       rvalid0_q;
  logic       rvalid1_q;
  owner_t     winner;
  logic [8:0] cnt_inc;
  logic       burst_done;

  mem_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .winner     (winner)
  );

  // Outputs are held at zero while reset is asserted, even mid-burst.
  assign gnt0    = !rst && (state == OWN0) && req0;
  assign gnt1    = !rst && (state == OWN1) && req1;
  assign rvalid0 = !rst && rvalid0_q;
  assign rvalid1 = !rst && rvalid1_q;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

  assign cnt_inc    = {1'b0, burst_cnt} + 9'd1;
  assign burst_done = cnt_inc >= {1'b0, BurstMax};

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= OWNER_DMA;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 && !we0;
      rvalid1_q <= gnt1 && !we1;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= (winner == OWNER_CPU) ? OWN0 : OWN1;
            last_owner <= winner;
            burst_cnt  <= '0;
          end
        end
        OWN0: begin
          if (!req0) begin
            burst_cnt <= '0;
            if (req1) begin
              state      <= OWN1;
              last_owner <= OWNER_DMA;
            end else begin
              state <= IDLE;
            end
          end else if (burst_done) begin
            if (req1) begin
              state      <= OWN1;
              last_owner <= OWNER_DMA;
              burst_cnt  <= '0;
            end else begin
              burst_cnt <= BurstMax;
            end
          end else begin
            burst_cnt <= cnt_inc[7:0];
          end
        end
        OWN1: begin
          if (!req1) begin
            burst_cnt <= '0;
            if (req0) begin
              state      <= OWN0;
              last_owner <= OWNER_CPU;
            end else begin
              state <= IDLE;
            end
          end else if (burst_done) begin
            if (req0) begin
              state      <= OWN0;
              last_owner <= OWNER_CPU;
              burst_cnt  <= '0;
            end else begin
              burst_cnt <= BurstMax;
            end
          end else begin
            burst_cnt <= cnt_inc[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the CPU's single-port 4K x 16 memory between the CPU core (requester 0) and a DMA/IO engine (requester 1). It sits between both masters and the memory macro and drives the memory's address, write-data and write-enable. Ownership is held by a registered state machine with a burst limit, so neither master can starve the other.

## Interface
Parameters:
- ADDR_W, 12, memory address width
- DATA_W, 16, memory data width
- MAX_BURST, 8, accesses an owner may complete back-to-back while the other requester waits; legal range 1..255

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1  access request from CPU / DMA
- we0, we1  in  1  1 = write, 0 = read; valid while req is high
- addr0, addr1  in  ADDR_W  access address
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  access accepted this cycle
- rvalid0, rvalid1  out  1  read data valid on rdata0/rdata1
- rdata0, rdata1  out  DATA_W  read data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data, one cycle after address

## Operation
- States: IDLE, OWN0, OWN1. Reset: IDLE, burst count 0, last_owner = 1. All outputs are 0 during and after reset until the first grant.
- gnt_i = (state == OWN_i) & req_i. This is a combinational decode of registered state. Only the owner's address, we and wdata are muxed to the memory. When no grant is active, mem_we = 0 and mem_addr/mem_wdata = 0.
- IDLE: if any req, go to the winner's OWN state. No access is issued in the arbitration cycle.
- OWN_i, req_i low: if req_other, go to OWN_other; else go to IDLE.
- OWN_i, req_i high: the access is accepted and the burst count increments. If count reaches MAX_BURST and req_other is high, go to OWN_other and clear the count. If req_other is low, stay in OWN_i with the count saturated.
- The burst count clears on every change of ownership. last_owner updates on every entry to an OWN state.
- Reads: rvalid_i is registered and asserted exactly one cycle after a read grant to requester i. rdata_i = mem_rdata for the owner of that pending read; otherwise 0.
- Requesters must hold req, we, addr and wdata stable until they see gnt. Dropping req before gnt is legal and withdraws the request.
- Simultaneous requests in IDLE are resolved per Configuration.

## Timing
- From IDLE: a request in cycle n is granted in cycle n+1. Read data follows in n+2.
- While owning: one access per cycle, with no bubbles.
- Hand-over: if the owner's req is low in cycle n, the other requester is granted in n+1. The same applies after a forced switch at the MAX_BURST-th access.
- A read pending at a hand-over still returns rvalid to its original requester in the following cycle.
- rst asserted mid-burst: in the next cycle the state is IDLE, the pending rvalid is dropped, and mem_we = 0.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a simultaneous request in IDLE, the requester that is not last_owner wins.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, req0 (CPU) always wins in IDLE. The MAX_BURST limit applies in both modes.

## Structure
- Shared package cpu_mem_pkg: arb_state_t enum (IDLE/OWN0/OWN1), owner ID constants OWNER_CPU = 0 and OWNER_DMA = 1, default ADDR_W/DATA_W.
- One sub-module, mem_arb_pick: a combinational winner select taking req0, req1, last_owner and the macro setting, and returning the winner ID.

## Test plan
- Reset, then req0 read to address 0x010 (memory holds 0x1234): gnt0 in cycle 1, rvalid0 with rdata0 = 0x1234 in cycle 2. gnt1 and rvalid1 stay 0.
- req0 and req1 asserted together from IDLE: CPU wins in fixed mode. With ARB_ROUND_ROBIN_EN and last_owner = 0, DMA wins.
- req0 held for 20 writes while req1 is high, MAX_BURST = 8: exactly 8 consecutive gnt0, then gnt1 the next cycle, with no idle cycle between them.
- req1 alone does 3 writes of 0xAAAA to addresses 0x100–0x102: mem_we is high for 3 cycles, and read-back by the CPU returns 0xAAAA at each address.
- CPU read granted in the last cycle before a hand-over to DMA: rvalid0 is asserted in the next cycle while gnt1 is active, and rvalid1 stays 0.
- rst pulsed during a DMA burst: the next cycle shows IDLE, all gnt/rvalid = 0 and mem_we = 0. The subsequent req0 is granted one cycle after rst deasserts.
